uart_tx_param: RTL and testbench

//  Parametrised UART transmitter; next generation of the fixed 8-bit TX controller.

---
 rtl/uart_tx_param.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_param.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with valid/ready input,
// programmable baud divider and configurable frame format. LSB first, idle high.
module uart_tx_param #(
    parameter int CLK_DIV   = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    output logic                 o_tx_serial,
    output logic                 o_tx_active,
    output logic                 o_tx_done
);

    // Elaboration-time parameter checks.
    if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
        $error("uart_tx_param: CLK_DIV must be 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end

    localparam int CW = $clog2(CLK_DIV);
    // Bit index is at least 3 bits wide (DATA_BITS >= 5), so it also counts stop bits.
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          idx_q, idx_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   par_q, par_d;
    logic                   serial_q, serial_d;
    logic                   ready_q, ready_d;
    logic                   active_q, active_d;
    logic                   done_q, done_d;
    logic                   baud_wrap;

    assign baud_wrap = (cnt_q == BAUD_LAST);

    // State and output registers; reset drops any frame in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            serial_q <= 1'b1;
            ready_q  <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            serial_q <= serial_d;
            ready_q  <= ready_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: every bit slot lasts CLK_DIV cycles, advancing on baud wrap.
    always_comb begin
        state_d  = state_q;
        cnt_d    = baud_wrap ? '0 : cnt_q + CW'(1);
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        serial_d = serial_q;
        ready_d  = ready_q;
        active_d = active_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d    = '0;
                idx_d    = '0;
                serial_d = 1'b1;
                ready_d  = 1'b1;
                active_d = 1'b0;
                if (i_tx_valid && ready_q) begin
                    state_d  = S_START;
                    shreg_d  = i_tx_data;
                    // Odd: bit set when data has an even count of ones.
                    par_d    = (PARITY == 1) ? ~^i_tx_data : ^i_tx_data;
                    serial_d = 1'b0;
                    ready_d  = 1'b0;
                    active_d = 1'b1;
                end
            end
            S_START: begin
                if (baud_wrap) begin
                    state_d  = S_DATA;
                    idx_d    = '0;
                    serial_d = shreg_q[0];
                    shreg_d  = shreg_q >> 1;
                end
            end
            S_DATA: begin
                if (baud_wrap) begin
                    if (idx_q == DATA_LAST) begin
                        idx_d = '0;
                        if (PARITY != 0) begin
                            state_d  = S_PARITY;
                            serial_d = par_q;
                        end else begin
                            state_d  = S_STOP;
                            serial_d = 1'b1;
                        end
                    end else begin
                        idx_d    = idx_q + BW'(1);
                        serial_d = shreg_q[0];
                        shreg_d  = shreg_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_wrap) begin
                    state_d  = S_STOP;
                    idx_d    = '0;
                    serial_d = 1'b1;
                end
            end
            S_STOP: begin
                serial_d = 1'b1;
                if (baud_wrap) begin
                    if (idx_q == STOP_LAST) begin
                        state_d  = S_IDLE;
                        idx_d    = '0;
                        done_d   = 1'b1;
                        active_d = 1'b0;
                        ready_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                idx_d    = '0;
                serial_d = 1'b1;
                ready_d  = 1'b1;
                active_d = 1'b0;
            end
        endcase
    end

    assign o_tx_ready  = ready_q;
    assign o_tx_serial = serial_q;
    assign o_tx_active = active_q;
    assign o_tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: several transmitter configurations run side by side, each
// compared every cycle against a frame-slot model of the serial line.
module tb_uart_tx_param;

    localparam int NCFG = 5;

    function automatic int cfg_c(int g);
        case (g)
            0, 1, 2: return 4;
            3:       return 3;
            default: return 2;
        endcase
    endfunction
    function automatic int cfg_d(int g);
        case (g)
            0, 1, 2: return 8;
            3:       return 7;
            default: return 5;
        endcase
    endfunction
    function automatic int cfg_p(int g);
        case (g)
            1:       return 2;
            2:       return 1;
            4:       return 1;
            default: return 0;
        endcase
    endfunction
    function automatic int cfg_s(int g);
        case (g)
            3, 4:    return 2;
            default: return 1;
        endcase
    endfunction
    function automatic int cfg_v(int g);
        case (g)
            0:       return 'hA5;
            1, 2:    return 'h07;
            3:       return 'h55;
            default: return 'h13;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NCFG-1:0] fin;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int C = cfg_c(g);
        localparam int D = cfg_d(g);
        localparam int P = cfg_p(g);
        localparam int S = cfg_s(g);
        localparam int L = 1 + D + ((P != 0) ? 1 : 0) + S;

        logic         rst_n = 1'b0;
        logic         vld   = 1'b0;
        logic [D-1:0] dat   = '0;
        logic         ser, rdy, act, dn;
        logic         bfin  = 1'b0;

        // Reference: line level per bit slot of the frame in flight.
        bit m_busy = 1'b0;
        bit m_done = 1'b0;
        int m_e    = 0;
        bit m_bits [16];

        uart_tx_param #(
            .CLK_DIV  (C),
            .DATA_BITS(D),
            .PARITY   (P),
            .STOP_BITS(S)
        ) dut (
            .clk        (clk),
            .reset_n    (rst_n),
            .i_tx_data  (dat),
            .i_tx_valid (vld),
            .o_tx_ready (rdy),
            .o_tx_serial(ser),
            .o_tx_active(act),
            .o_tx_done  (dn)
        );

        assign fin[g] = bfin;

        // Model advances at each edge, DUT compared at the following negedge.
        initial begin
            int ones;
            forever begin
                @(posedge clk);
                if (!rst_n) begin
                    m_busy = 1'b0;
                    m_done = 1'b0;
                end else if (m_busy) begin
                    m_e++;
                    m_done = (m_e == L * C);
                    if (m_done) m_busy = 1'b0;
                end else begin
                    m_done = 1'b0;
                    if (vld) begin
                        m_bits[0] = 1'b0;
                        for (int i = 0; i < D; i++) m_bits[1 + i] = dat[i];
                        ones = $countones(dat);
                        if (P != 0) m_bits[1 + D] = (P == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
                        for (int i = 0; i < S; i++) m_bits[L - S + i] = 1'b1;
                        m_busy = 1'b1;
                        m_e    = 0;
                    end
                end
                @(negedge clk);
                if (!rst_n)
                    chk($sformatf("cfg%0d rst c%0d", g, cyc), 32'({ser, rdy, act, dn}), 32'h0000_000c);
                else
                    chk($sformatf("cfg%0d line c%0d", g, cyc), 32'({ser, rdy, act, dn}),
                        32'({(m_busy ? m_bits[m_e / C] : 1'b1), !m_busy, m_busy, m_done}));
            end
        end

        task automatic step();
            @(negedge clk);
            #1;
        endtask

        task automatic wait_idle();
            while (m_busy) step();
        endtask

        // Send one word from idle and time acceptance edge to done pulse.
        task automatic send_meas(input logic [D-1:0] v);
            int n;
            vld = 1'b1;
            dat = v;
            n   = 0;
            do begin
                step();
                n++;
                vld = 1'b0;
                dat = D'($urandom);
            end while (!dn && n < 400);
            chk($sformatf("cfg%0d frame_len", g), 32'(n - 1), 32'(L * C));
        endtask

        initial begin
            repeat (3) step();
            rst_n = 1'b1;
            step();
            // Directed frame (0xA5 / 0x07 / 0x55 ...) and its length.
            send_meas(D'(cfg_v(g)));
            wait_idle();
            // Back-to-back with valid held: 0x00 then all ones; data changes while busy.
            vld = 1'b1;
            dat = '0;
            step();
            dat = '1;
            wait_idle();
            step();
            vld = 1'b0;
            wait_idle();
            // Reset in the middle of the data bits.
            vld = 1'b1;
            dat = D'($urandom);
            step();
            vld = 1'b0;
            repeat (3 * C) step();
            @(posedge clk);
            #2 rst_n = 1'b0;
            #1 chk($sformatf("cfg%0d rst_async", g), 32'({ser, rdy, act, dn}), 32'h0000_000c);
            step();
            step();
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
            step();
            // First word after reset is accepted normally.
            send_meas(D'($urandom));
            wait_idle();
            // Random valid/data traffic, including pulses while busy.
            repeat (600) begin
                step();
                vld = ($urandom_range(0, 3) != 0);
                dat = D'($urandom);
            end
            vld = 1'b0;
            wait_idle();
            step();
            bfin = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (fin !== {NCFG{1'b1}} && t < 20000) begin
            @(posedge clk);
            t++;
        end
        chk("all_done", 32'(fin), 32'((1 << NCFG) - 1));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
